// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared encodings and helpers for the branch controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

   localparam logic [4:0] OP_BEQ  = 5'd0;
   localparam logic [4:0] OP_BNE  = 5'd1;
   localparam logic [4:0] OP_BLTZ = 5'd2;
   localparam logic [4:0] OP_BGEZ = 5'd3;
   localparam logic [4:0] OP_BGTZ = 5'd4;
   localparam logic [4:0] OP_BLEZ = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_OPND = 2'd1,
      ST_REDIRECT  = 2'd2
   } br_state_e;

   localparam logic [31:0] INIT_32   = 32'h0;
   localparam int          BHT_IDX_W = 4;
   localparam int          BHT_DEPTH = 1 << BHT_IDX_W;
   localparam logic [1:0]  BHT_INIT  = 2'b01;

   function automatic logic br_cond(input logic [4:0]  op,
                                    input logic [31:0] rs,
                                    input logic [31:0] rt);
      logic r;
      r = 1'b0;
      case (op)
         OP_BEQ:  r = (rs == rt);
         OP_BNE:  r = (rs != rt);
         OP_BLTZ: r = rs[31];
         OP_BGEZ: r = !rs[31];
         OP_BGTZ: r = !rs[31] && (rs != 32'h0);
         OP_BLEZ: r = rs[31] || (rs == 32'h0);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Two-bit saturating step toward the resolved outcome.
   function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
      logic [1:0] n;
      n = cnt;
      if (taken && cnt != 2'b11)
         n = cnt + 2'b01;
      else if (!taken && cnt != 2'b00)
         n = cnt - 2'b01;
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_bht.sv
// ============================================================================
// Module      : branch_bht
// Description : 16-entry 2-bit saturating branch history table.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_bht
   import branch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BHT_IDX_W-1:0] rd_idx_i,
   output logic                 rd_taken_o,
   input  logic                 upd_en_i,
   input  logic [BHT_IDX_W-1:0] upd_idx_i,
   input  logic                 upd_taken_i
);

   logic [1:0] cnt_q [BHT_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++)
            cnt_q[i] <= BHT_INIT;
      end else if (upd_en_i) begin
         cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
      end
   end

   assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// Module      : branch_ctrl
// Description : ID-stage branch resolver with one-cycle registered redirect.
//               Define BRANCH_PREDICT_EN to add the BHT predictor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_ctrl
   import branch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   input  logic [4:0]  br_op,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_target,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        rs_ready,
   input  logic        rt_ready,
   input  logic        br_pred_taken,
   input  logic        flush_in,
   input  logic [31:0] if_pc,
   output logic        br_ready,
   output logic        stall_id,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_if,
   output logic        if_pred_taken
);

   br_state_e   state_q;
   logic        redirect_valid_q;
   logic        flush_if_q;
   logic [31:0] redirect_pc_q;

   logic        opnd_ok;
   logic        want_eval;
   logic        eval;
   logic        taken;
   logic        mispredict;
   logic [31:0] target_d;

   assign opnd_ok    = rs_ready && rt_ready;
   assign want_eval  = (state_q == ST_WAIT_OPND) || ((state_q == ST_IDLE) && br_valid);
   // A later-stage flush wins over a branch resolving in the same cycle.
   assign eval       = want_eval && opnd_ok && !flush_in;
   assign taken      = br_cond(br_op, rs_data, rt_data);
   assign mispredict = taken != br_pred_taken;
   assign target_d   = taken ? br_target : br_pc + 32'd4;

   assign br_ready       = eval;
   assign stall_id       = want_eval && !opnd_ok;
   assign redirect_valid = redirect_valid_q;
   assign flush_if       = flush_if_q;
   assign redirect_pc    = redirect_pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         redirect_valid_q <= 1'b0;
         flush_if_q       <= 1'b0;
         redirect_pc_q    <= INIT_32;
      end else begin
         redirect_valid_q <= eval && mispredict;
         flush_if_q       <= eval && mispredict;
         if (eval && mispredict)
            redirect_pc_q <= target_d;

         if (flush_in) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (eval && mispredict)
                     state_q <= ST_REDIRECT;
                  else if (br_valid && !opnd_ok)
                     state_q <= ST_WAIT_OPND;
               end
               ST_WAIT_OPND: begin
                  if (eval)
                     state_q <= mispredict ? ST_REDIRECT : ST_IDLE;
               end
               ST_REDIRECT: state_q <= ST_IDLE;
               default:     state_q <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef BRANCH_PREDICT_EN
   logic unused_if_pc_bits;
   assign unused_if_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

   branch_bht u_bht (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (if_pc[BHT_IDX_W+1:2]),
      .rd_taken_o  (if_pred_taken),
      .upd_en_i    (eval),
      .upd_idx_i   (br_pc[BHT_IDX_W+1:2]),
      .upd_taken_i (taken)
   );
`else
   logic unused_if_pc;
   assign unused_if_pc  = ^if_pc;
   assign if_pred_taken = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Directed self-checking bench for branch_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_ctrl;
   import branch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br_valid, rs_ready, rt_ready, br_pred_taken, flush_in;
   logic [4:0]  br_op;
   logic [31:0] br_pc, br_target, rs_data, rt_data, if_pc;
   logic        br_ready, stall_id, redirect_valid, flush_if, if_pred_taken;
   logic [31:0] redirect_pc;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   always #5 clk = ~clk;

   branch_ctrl dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .br_pc(br_pc),
      .br_target(br_target), .rs_data(rs_data), .rt_data(rt_data),
      .rs_ready(rs_ready), .rt_ready(rt_ready), .br_pred_taken(br_pred_taken),
      .flush_in(flush_in), .if_pc(if_pc), .br_ready(br_ready), .stall_id(stall_id),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if(flush_if), .if_pred_taken(if_pred_taken)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a branch is either absent, waiting on operands, or owed a redirect.
   bit          m_wait, m_redir;
   logic [31:0] m_rpc;
   int          m_cnt [16];

   function automatic bit model_taken(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt);
      int s = rs;
      case (op)
         OP_BEQ:  return rs == rt;
         OP_BNE:  return rs != rt;
         OP_BLTZ: return s < 0;
         OP_BGEZ: return s >= 0;
         OP_BGTZ: return s > 0;
         OP_BLEZ: return s <= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit branch_present();
      return m_wait || (br_valid && !m_redir);
   endfunction

   function automatic bit exp_ready();
      return branch_present() && rs_ready && rt_ready && !flush_in;
   endfunction

   function automatic bit exp_stall();
      return branch_present() && !(rs_ready && rt_ready);
   endfunction

   function automatic bit exp_pred();
`ifdef BRANCH_PREDICT_EN
      return m_cnt[if_pc[5:2]] >= 2;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      bit ev, tk, st;
      if (rst) begin
         m_wait  = 1'b0;
         m_redir = 1'b0;
         m_rpc   = 32'h0;
         for (int i = 0; i < 16; i++) m_cnt[i] = 1;
      end else begin
         ev = exp_ready();
         st = exp_stall();
         tk = model_taken(br_op, rs_data, rt_data);
         if (ev) begin
            if (tk && m_cnt[br_pc[5:2]] < 3) m_cnt[br_pc[5:2]] = m_cnt[br_pc[5:2]] + 1;
            if (!tk && m_cnt[br_pc[5:2]] > 0) m_cnt[br_pc[5:2]] = m_cnt[br_pc[5:2]] - 1;
         end
         m_wait  = st && !flush_in;
         m_redir = ev && (tk != br_pred_taken);
         if (m_redir) m_rpc = tk ? br_target : br_pc + 32'd4;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cmp_br_ready", br_ready, exp_ready());
         chk("cmp_stall_id", stall_id, exp_stall());
         chk("cmp_redirect_valid", redirect_valid, m_redir);
         chk("cmp_flush_if", flush_if, m_redir);
         chk("cmp_redirect_pc", redirect_pc, m_rpc);
         chk("cmp_if_pred_taken", if_pred_taken, exp_pred());
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic br(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic rsr, input logic rtr, input logic pred);
      br_valid = 1'b1; br_op = op; br_pc = pc; br_target = tgt;
      rs_data = rs; rt_data = rt; rs_ready = rsr; rt_ready = rtr; br_pred_taken = pred;
   endtask

   task automatic idle();
      br_valid = 1'b0; rs_ready = 1'b1; rt_ready = 1'b1; flush_in = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      br_valid = 0; br_op = OP_BEQ; br_pc = 0; br_target = 0; rs_data = 0; rt_data = 0;
      rs_ready = 1; rt_ready = 1; br_pred_taken = 0; flush_in = 0; if_pc = 32'h40;
      rst = 1'b1;
      nxt(); nxt();
      started = 1'b1;
      mid();
      chk("rst_br_ready", br_ready, 0);
      chk("rst_stall_id", stall_id, 0);
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_flush_if", flush_if, 0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_if_pred_taken", if_pred_taken, 0);
      nxt(); rst = 1'b0;

      // BEQ taken, predicted not-taken
      br(OP_BEQ, 32'h40, 32'h100, 32'h5, 32'h5, 1, 1, 0);
      mid(); chk("beq_br_ready_c0", br_ready, 1); chk("beq_rv_c0", redirect_valid, 0);
      nxt(); idle();
      mid(); chk("beq_rv_c1", redirect_valid, 1); chk("beq_pc_c1", redirect_pc, 32'h100);
      chk("beq_flush_c1", flush_if, 1);
      nxt();
      mid(); chk("beq_rv_c2", redirect_valid, 0); chk("beq_flush_c2", flush_if, 0);

      // BNE not taken, correctly predicted
      nxt(); br(OP_BNE, 32'h44, 32'h180, 32'h7, 32'h7, 1, 1, 0);
      mid(); chk("bne_br_ready", br_ready, 1);
      nxt(); idle();
      mid(); chk("bne_rv", redirect_valid, 0); chk("bne_stall", stall_id, 0);

      // BLTZ with rs not ready for three cycles
      nxt(); br(OP_BLTZ, 32'h80, 32'h200, 32'hFFFF_FFFF, 32'h0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         mid(); chk("bltz_stall", stall_id, 1); chk("bltz_br_ready_wait", br_ready, 0);
         nxt();
      end
      rs_ready = 1'b1;
      mid(); chk("bltz_stall_rel", stall_id, 0); chk("bltz_br_ready", br_ready, 1);
      nxt(); idle();
      mid(); chk("bltz_rv", redirect_valid, 1); chk("bltz_pc", redirect_pc, 32'h200);

      // BGTZ not taken, predicted taken, fall-through wraps
      nxt(); br(OP_BGTZ, 32'hFFFF_FFFC, 32'h300, 32'h0, 32'h0, 1, 1, 1);
      mid(); chk("bgtz_br_ready", br_ready, 1);
      nxt(); idle();
      mid(); chk("bgtz_rv", redirect_valid, 1); chk("bgtz_pc_wrap", redirect_pc, 32'h0);

      // flush while waiting, coinciding with operands becoming ready
      nxt(); br(OP_BEQ, 32'h48, 32'h400, 32'h1, 32'h1, 0, 0, 0);
      mid(); chk("flush_stall_pre", stall_id, 1);
      nxt(); rs_ready = 1'b1; rt_ready = 1'b1; flush_in = 1'b1;
      nxt(); flush_in = 1'b0; br_valid = 1'b0; rs_ready = 1'b0;
      mid(); chk("flush_rv", redirect_valid, 0); chk("flush_idle_stall", stall_id, 0);
      nxt(); idle();

      // wrong-path branch during REDIRECT is ignored
      br(OP_BEQ, 32'h4C, 32'h500, 32'h2, 32'h2, 1, 1, 0);
      nxt(); br(OP_BNE, 32'h50, 32'h600, 32'h1, 32'h2, 1, 1, 0);
      mid(); chk("wp_br_ready", br_ready, 0); chk("wp_pc", redirect_pc, 32'h500);
      nxt(); idle();
      mid(); chk("wp_rv", redirect_valid, 0);

      // reset while in REDIRECT
      nxt(); br(OP_BEQ, 32'h54, 32'h700, 32'h3, 32'h3, 1, 1, 0);
      nxt(); idle(); rst = 1'b1;
      mid(); chk("rstr_rv", redirect_valid, 0); chk("rstr_flush", flush_if, 0);
      nxt(); rst = 1'b0;
      mid(); chk("rstr_rv_after", redirect_valid, 0); chk("rstr_stall", stall_id, 0);

      // predictor training at pc 0x40
      if_pc = 32'h40;
      for (int i = 0; i < 3; i++) begin
         nxt(); br(OP_BEQ, 32'h40, 32'h800, 32'h9, 32'h9, 1, 1, 1);
      end
      nxt(); idle();
`ifdef BRANCH_PREDICT_EN
      mid(); chk("bht_trained", if_pred_taken, 1);
      if_pc = 32'h44;
      mid(); chk("bht_other_idx", if_pred_taken, 0);
      if_pc = 32'h40;
      nxt(); br(OP_BNE, 32'h40, 32'h800, 32'h9, 32'h9, 1, 1, 1);
      nxt(); idle();
      mid(); chk("bht_sat_11_to_10", if_pred_taken, 1);
      nxt(); br(OP_BNE, 32'h40, 32'h800, 32'h9, 32'h9, 1, 1, 0);
      nxt(); idle();
      mid(); chk("bht_10_to_01", if_pred_taken, 0);
`else
      mid(); chk("nobht_pred", if_pred_taken, 0);
`endif
      nxt();
      mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
